// File: rtl/icon_opd_fetch.sv
// Operand fetch initiator: queues tagged reads, retries the producer EU, hands data to the consumer.
// Latency: push into empty queue -> eu_rvalid_o 2 cycles later; EU success -> opd_valid_o next cycle.
// Backpressure: req_ready_o drops when the 4-entry queue is full; opd_valid_o holds until opd_ready_i.
module icon_opd_fetch #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 32,
    parameter int LOG2_REQ_DEPTH = 2,
    parameter int RETRY_GAP      = 3,
    parameter int MAX_RETRIES    = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    output logic [ADDR_W-1:0] eu_raddr_o,
    output logic              eu_rvalid_o,
    input  logic [DATA_W-1:0] eu_rdata_i,
    input  logic              eu_rsuccess_i,
    output logic [DATA_W-1:0] opd_data_o,
    output logic [ADDR_W-1:0] opd_addr_o,
    output logic              opd_valid_o,
    input  logic              opd_ready_i,
    output logic              err_timeout_o,
    output logic              busy_o
);

    localparam int DEPTH = 1 << LOG2_REQ_DEPTH;
    localparam int RC_W  = $clog2(MAX_RETRIES + 1);
    localparam int GAP_W = $clog2(RETRY_GAP + 1);
    localparam logic [RC_W-1:0]  RC_MAX  = RC_W'(MAX_RETRIES);
    localparam logic [GAP_W-1:0] GAP_INI = GAP_W'(RETRY_GAP);

    typedef enum logic [1:0] {IDLE, REQ, BACKOFF, DELIVER} state_t;

    state_t                    state, state_nxt;
    logic [ADDR_W-1:0]         mem [DEPTH];
    logic [LOG2_REQ_DEPTH:0]   wr_ptr, rd_ptr;
    logic                      full, empty, push, pop, success;
    logic [ADDR_W-1:0]         head_addr;
    logic [RC_W-1:0]           retry_cnt;
    logic [GAP_W-1:0]          gap_cnt;
    logic [DATA_W-1:0]         opd_data_q;
    logic [ADDR_W-1:0]         opd_addr_q;
    logic                      err_q;

    // Extra pointer MSB tells full from empty when the index bits match.
    assign full      = (wr_ptr[LOG2_REQ_DEPTH] != rd_ptr[LOG2_REQ_DEPTH]) &&
                       (wr_ptr[LOG2_REQ_DEPTH-1:0] == rd_ptr[LOG2_REQ_DEPTH-1:0]);
    assign empty     = (wr_ptr == rd_ptr);
    assign push      = req_valid_i && !full;
    assign success   = (state == REQ) && eu_rsuccess_i;
    assign pop       = success;
    assign head_addr = mem[rd_ptr[LOG2_REQ_DEPTH-1:0]];

    assign req_ready_o   = !full;
    assign eu_rvalid_o   = (state == REQ);
    assign eu_raddr_o    = (state == REQ) ? head_addr : '0;
    assign opd_valid_o   = (state == DELIVER);
    assign opd_data_o    = opd_data_q;
    assign opd_addr_o    = opd_addr_q;
    assign err_timeout_o = err_q;
    assign busy_o        = !empty || (state != IDLE);

    // Queue storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[LOG2_REQ_DEPTH-1:0]] <= req_addr_i;
        end
    end

    // Queue pointers; reset drops every queued request.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state: one read outstanding, head-of-queue order.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!empty) state_nxt = REQ;
            REQ:     state_nxt = eu_rsuccess_i ? DELIVER : BACKOFF;
            BACKOFF: if (gap_cnt <= 1) state_nxt = REQ;
            DELIVER: if (opd_ready_i) state_nxt = empty ? IDLE : REQ;
            default: state_nxt = IDLE;
        endcase
    end

    // Retry/gap counters and the one-shot timeout pulse when the count first reaches its limit.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            retry_cnt <= '0;
            gap_cnt   <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (state == REQ) begin
                if (eu_rsuccess_i) begin
                    retry_cnt <= '0;
                end else begin
                    if (retry_cnt < RC_MAX)             retry_cnt <= retry_cnt + 1'b1;
                    if (retry_cnt == RC_MAX - 1'b1)     err_q     <= 1'b1;
                    gap_cnt <= GAP_INI;
                end
            end else if (state == BACKOFF) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
        end
    end

    // Capture returned data and its tag; held stable through DELIVER.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            opd_data_q <= '0;
            opd_addr_q <= '0;
        end else if (success) begin
            opd_data_q <= eu_rdata_i;
            opd_addr_q <= head_addr;
        end
    end

endmodule
